// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB/MULDIV/TRAP control with memory timeout.
// Optional iterative MUL/DIV sequencing is enabled by defining RV_MULDIV_EN.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned DIV_LAT  = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_control,
    output logic        md_start,
    output logic        instret,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_MULDIV = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

`ifdef RV_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MD_W   = (MD_MAX < 2) ? 1 : $clog2(MD_MAX);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [MD_W-1:0]     md_cnt_q, md_cnt_d;
    logic [1:0]          trap_cause_q, trap_cause_d;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                illegal;
    logic                is_muldiv;
    logic                is_store;
    logic                mem_phase;
    logic                timeout;
    logic [MD_W-1:0]     md_last;
    logic                unused_instr_bits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign is_store = (opcode == OP_STORE);
    assign md_last  = instr[14] ? MD_W'(DIV_LAT - 1) : MD_W'(MUL_LAT - 1);
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    function automatic logic [3:0] alu_func(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Legality only depends on the IR, so it is evaluated every cycle and consumed in DECODE.
    always_comb begin
        illegal   = 1'b0;
        is_muldiv = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_FENCE, OP_SYSTEM: illegal = 1'b0;
            OP_OP: begin
                if (funct7 == 7'b0000000) begin
                    illegal = 1'b0;
                end else if (funct7 == 7'b0100000) begin
                    illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                end else if (funct7 == 7'b0000001) begin
                    illegal   = !MD_EN;
                    is_muldiv = MD_EN;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout   = (MAX_WAIT != 0) && mem_phase && !mem_ack &&
                       (wait_cnt_q == WAIT_W'(MAX_WAIT));

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_iord     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 1'b0;
        alu_control  = ALU_ADD;
        md_start     = 1'b0;
        instret      = 1'b0;
        trap         = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_OP: begin
                        if (is_muldiv) begin
                            state_d = S_MULDIV;
                        end else begin
                            alu_control = alu_func(funct3, instr[30]);
                            reg_write   = 1'b1;
                            pc_write    = 1'b1;
                            instret     = 1'b1;
                        end
                    end
                    OP_IMM: begin
                        alu_control = alu_func(funct3, (funct3 == 3'b101) && instr[30]);
                        alu_src_b   = 1'b1;
                        reg_write   = 1'b1;
                        pc_write    = 1'b1;
                        instret     = 1'b1;
                    end
                    OP_LUI, OP_AUIPC: begin
                        alu_src_a = (opcode == OP_LUI) ? 2'b10 : 2'b01;
                        alu_src_b = 1'b1;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        instret   = 1'b1;
                    end
                    OP_BRANCH: begin
                        case (funct3[2:1])
                            2'b10:   alu_control = ALU_SLT;
                            2'b11:   alu_control = ALU_SLTU;
                            default: alu_control = ALU_SUB;
                        endcase
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                        instret  = 1'b1;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b01;
                        instret   = 1'b1;
                    end
                    OP_JALR: begin
                        alu_src_b = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        instret   = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    default: begin
                        pc_write = 1'b1;
                        instret  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_iord  = 1'b1;
                mem_we    = is_store;
                alu_src_b = 1'b1;
                if (mem_ack) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        instret  = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                pc_write  = 1'b1;
                instret   = 1'b1;
                state_d   = S_FETCH;
            end
            S_MULDIV: begin
`ifdef RV_MULDIV_EN
                md_start = (md_cnt_q == '0);
`endif
                if (md_cnt_q == md_last) begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b11;
                    pc_write  = 1'b1;
                    instret   = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_src   = 2'b11;
                state_d  = S_FETCH;
            end
        endcase
    end

    // Both counters restart whenever the state changes, so each phase starts from zero.
    always_comb begin
        wait_cnt_d = '0;
        md_cnt_d   = '0;
        if ((state_d == state_q) && mem_phase && !mem_ack) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((state_q == S_MULDIV) && (state_d == S_MULDIV)) begin
            md_cnt_d = md_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            wait_cnt_q   <= '0;
            md_cnt_q     <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            md_cnt_q     <= md_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign trap_cause = trap_cause_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction walks, memory waits, timeout, traps, reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ack;
    logic        branch_taken;
    logic        mem_req, mem_we, mem_iord, ir_write, pc_write;
    logic [1:0]  pc_src, wb_sel, alu_src_a, trap_cause;
    logic        reg_write, alu_src_b, md_start, instret, trap;
    logic [3:0]  alu_control;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_err    = 0;
    int n_ret    = 0;
    int r0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h00002083;
    localparam logic [31:0] I_SW   = 32'h00102023;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_BNE  = 32'h00101463;
    localparam logic [31:0] I_SUB  = 32'h403100b3;
    localparam logic [31:0] I_BADR = 32'h40001033;
    localparam logic [31:0] I_BADO = 32'h0000007f;
    localparam logic [31:0] I_MUL  = 32'h02208033;

    multicycle_ctrl #(.MAX_WAIT(15), .MUL_LAT(4), .DIV_LAT(33)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_iord(mem_iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .md_start(md_start), .instret(instret), .trap(trap),
        .trap_cause(trap_cause), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (instret) n_ret++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs for a cycle are driven 1 time unit after its rising edge; checks follow 1 unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b1; branch_taken = 1'b0; instr = I_ADDI;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_trap_cause", trap_cause, 0);
        #11 rst_n = 1'b1;
        #1 chk("rst_release_state", state_o, 0);

        // addi x1,x0,5 with zero-wait memory
        cycle(); #1;
        chk("addi_fetch_state", state_o, 1);
        chk("addi_fetch_req", mem_req, 1);
        chk("addi_fetch_irw", ir_write, 1);
        chk("addi_fetch_iord", mem_iord, 0);
        cycle(); #1;
        chk("addi_dec_state", state_o, 2);
        chk("addi_dec_regw", reg_write, 0);
        cycle(); #1;
        chk("addi_exec_state", state_o, 3);
        chk("addi_exec_regw", reg_write, 1);
        chk("addi_exec_alu", alu_control, 0);
        chk("addi_exec_srcb", alu_src_b, 1);
        chk("addi_exec_instret", instret, 1);
        chk("addi_exec_pcsrc", pc_src, 0);

        // lw with 3 wait cycles in MEM
        cycle(); instr = I_LW; #1;
        chk("lw_fetch_state", state_o, 1);
        cycle(); #1;
        chk("lw_dec_state", state_o, 2);
        cycle(); #1;
        chk("lw_exec_state", state_o, 3);
        chk("lw_exec_instret", instret, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(); mem_ack = (i == 3); #1;
            chk("lw_mem_state", state_o, 4);
            chk("lw_mem_iord", mem_iord, 1);
            chk("lw_mem_we", mem_we, 0);
        end
        cycle(); #1;
        chk("lw_wb_state", state_o, 5);
        chk("lw_wb_sel", wb_sel, 1);
        chk("lw_wb_regw", reg_write, 1);
        chk("lw_wb_instret", instret, 1);

        // sw zero-wait: 4 cycles
        cycle(); instr = I_SW; #1;
        chk("sw_fetch_state", state_o, 1);
        cycle(); cycle(); #1;
        chk("sw_exec_instret", instret, 0);
        cycle(); #1;
        chk("sw_mem_state", state_o, 4);
        chk("sw_mem_we", mem_we, 1);
        chk("sw_mem_instret", instret, 1);

        // FETCH timeout: 16 unacked cycles trap with bus error
        cycle(); mem_ack = 1'b0; #1;
        chk("to_fetch_1", state_o, 1);
        for (int i = 2; i <= 16; i++) begin
            cycle(); #1;
            chk("to_fetch_n", state_o, 1);
        end
        cycle(); #1;
        chk("to_trap_state", state_o, 7);
        chk("to_trap", trap, 1);
        chk("to_trap_cause", trap_cause, 2);
        chk("to_trap_pcsrc", pc_src, 3);
        chk("to_trap_pcw", pc_write, 1);
        chk("to_trap_instret", instret, 0);

        // Same wait but ack arrives on cycle 16: no trap
        cycle(); instr = I_BEQ; #1;
        chk("ack16_fetch_1", state_o, 1);
        for (int i = 2; i <= 15; i++) begin
            cycle(); #1;
            chk("ack16_fetch_n", state_o, 1);
        end
        cycle(); mem_ack = 1'b1; #1;
        chk("ack16_fetch_16", state_o, 1);
        chk("ack16_irw", ir_write, 1);
        cycle(); branch_taken = 1'b1; #1;
        chk("ack16_decode", state_o, 2);
        chk("cause_hold", trap_cause, 2);

        // beq taken, bne not taken
        cycle(); #1;
        chk("beq_pcsrc", pc_src, 1);
        chk("beq_pcw", pc_write, 1);
        chk("beq_regw", reg_write, 0);
        chk("beq_alu", alu_control, 1);
        chk("beq_instret", instret, 1);
        cycle(); instr = I_BNE; branch_taken = 1'b0; #1;
        cycle(); cycle(); #1;
        chk("bne_state", state_o, 3);
        chk("bne_pcsrc", pc_src, 0);
        chk("bne_pcw", pc_write, 1);
        chk("bne_regw", reg_write, 0);

        // sub: legal funct7=0100000 with funct3=000
        cycle(); instr = I_SUB; #1;
        cycle(); cycle(); #1;
        chk("sub_state", state_o, 3);
        chk("sub_alu", alu_control, 1);
        chk("sub_srcb", alu_src_b, 0);
        chk("sub_regw", reg_write, 1);

        // Illegal R-type funct7=0100000 funct3=001
        cycle(); instr = I_BADR; r0 = n_ret; #1;
        cycle(); #1;
        chk("badr_dec_instret", instret, 0);
        cycle(); #1;
        chk("badr_trap_state", state_o, 7);
        chk("badr_cause", trap_cause, 1);
        chk("badr_instret", instret, 0);

        // Illegal opcode 0x7F
        cycle(); instr = I_BADO; #1;
        chk("bado_fetch", state_o, 1);
        cycle(); cycle(); #1;
        chk("bado_trap_state", state_o, 7);
        chk("bado_cause", trap_cause, 1);
        chk("bado_pcsrc", pc_src, 3);
        cycle(); #1;
        chk("bado_refetch", state_o, 1);
        chk("trap_no_instret", n_ret, r0);

        // mul
        instr = I_MUL;
        cycle(); #1;
        chk("mul_dec", state_o, 2);
`ifdef RV_MULDIV_EN
        cycle(); #1;
        chk("mul_exec", state_o, 3);
        chk("mul_exec_start", md_start, 0);
        cycle(); #1;
        chk("mul_md1_state", state_o, 6);
        chk("mul_md1_start", md_start, 1);
        chk("mul_md1_regw", reg_write, 0);
        cycle(); #1;
        chk("mul_md2_start", md_start, 0);
        cycle(); #1;
        chk("mul_md3_regw", reg_write, 0);
        cycle(); #1;
        chk("mul_md4_state", state_o, 6);
        chk("mul_md4_regw", reg_write, 1);
        chk("mul_md4_wbsel", wb_sel, 3);
        chk("mul_md4_instret", instret, 1);
        cycle(); #1;
        chk("mul_done_fetch", state_o, 1);
        cycle(); cycle(); cycle(); cycle(); #1;
        chk("mul2_md2_state", state_o, 6);
        rst_n = 1'b0; #1;
        chk("midrst_state", state_o, 0);
        chk("midrst_regw", reg_write, 0);
        chk("midrst_start", md_start, 0);
        chk("midrst_cause", trap_cause, 0);
`else
        cycle(); #1;
        chk("mul_trap_state", state_o, 7);
        chk("mul_trap_cause", trap_cause, 1);
        chk("mul_trap_instret", instret, 0);
        chk("mul_md_start", md_start, 0);
        cycle(); instr = I_ADDI; #1;
        chk("mul_refetch", state_o, 1);
        cycle(); cycle(); #1;
        chk("midrst_pre_regw", reg_write, 1);
        rst_n = 1'b0; #1;
        chk("midrst_state", state_o, 0);
        chk("midrst_regw", reg_write, 0);
        chk("midrst_cause", trap_cause, 0);
`endif
        #3 rst_n = 1'b1;
        instr = I_ADDI;
        cycle(); #1;
        chk("post_rst_fetch", state_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
